// File: rtl/hmc_to_axi_if.sv
// Bundle of the HMC command/data ports and the AXI4 master channels of hmc_to_axi.
// The master modport is the bridge's view; slave is the view of the surrounding system.
interface hmc_to_axi_if #(
    parameter int C_AXI_ID_WIDTH   = 6,
    parameter int C_AXI_ADDR_WIDTH = 34
);
    logic                        hmc_cmd_valid;
    logic                        hmc_cmd_ready;
    logic [3:0]                  hmc_cmd;
    logic [C_AXI_ADDR_WIDTH-1:0] hmc_addr;
    logic [3:0]                  hmc_size;
    logic [5:0]                  hmc_tag;
    logic [127:0]                hmc_wr_data;
    logic                        hmc_wr_data_valid;
    logic                        hmc_wr_data_ready;
    logic [127:0]                hmc_rd_data;
    logic [5:0]                  hmc_rd_data_tag;
    logic                        hmc_rd_data_valid;
    logic                        hmc_rd_data_ready;
    logic [6:0]                  hmc_errstat;
    logic                        hmc_dinv;
    logic                        bad_cmd;
    logic                        wr_err;

    logic                        axi_awvalid;
    logic                        axi_awready;
    logic [C_AXI_ID_WIDTH-1:0]   axi_awid;
    logic [C_AXI_ADDR_WIDTH-1:0] axi_awaddr;
    logic [7:0]                  axi_awlen;
    logic [2:0]                  axi_awsize;
    logic [1:0]                  axi_awburst;
    logic                        axi_awlock;
    logic [3:0]                  axi_awcache;
    logic [2:0]                  axi_awprot;
    logic [3:0]                  axi_awqos;

    logic [127:0]                axi_wdata;
    logic [15:0]                 axi_wstrb;
    logic                        axi_wlast;
    logic                        axi_wvalid;
    logic                        axi_wready;

    logic [C_AXI_ID_WIDTH-1:0]   axi_bid;
    logic [1:0]                  axi_bresp;
    logic                        axi_bvalid;
    logic                        axi_bready;

    logic                        axi_arvalid;
    logic                        axi_arready;
    logic [C_AXI_ID_WIDTH-1:0]   axi_arid;
    logic [C_AXI_ADDR_WIDTH-1:0] axi_araddr;
    logic [7:0]                  axi_arlen;
    logic [2:0]                  axi_arsize;
    logic [1:0]                  axi_arburst;
    logic                        axi_arlock;
    logic [3:0]                  axi_arcache;
    logic [2:0]                  axi_arprot;
    logic [3:0]                  axi_arqos;

    logic [C_AXI_ID_WIDTH-1:0]   axi_rid;
    logic [1:0]                  axi_rresp;
    logic [127:0]                axi_rdata;
    logic                        axi_rlast;
    logic                        axi_rvalid;
    logic                        axi_rready;

    modport master (
        input  hmc_cmd_valid, hmc_cmd, hmc_addr, hmc_size, hmc_tag,
        output hmc_cmd_ready,
        input  hmc_wr_data, hmc_wr_data_valid,
        output hmc_wr_data_ready,
        output hmc_rd_data, hmc_rd_data_tag, hmc_rd_data_valid,
        input  hmc_rd_data_ready,
        output hmc_errstat, hmc_dinv, bad_cmd, wr_err,
        output axi_awvalid, axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
               axi_awlock, axi_awcache, axi_awprot, axi_awqos,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_bvalid,
        output axi_bready,
        output axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
               axi_arlock, axi_arcache, axi_arprot, axi_arqos,
        input  axi_arready,
        input  axi_rid, axi_rresp, axi_rdata, axi_rlast, axi_rvalid,
        output axi_rready
    );

    modport slave (
        output hmc_cmd_valid, hmc_cmd, hmc_addr, hmc_size, hmc_tag,
        input  hmc_cmd_ready,
        output hmc_wr_data, hmc_wr_data_valid,
        input  hmc_wr_data_ready,
        input  hmc_rd_data, hmc_rd_data_tag, hmc_rd_data_valid,
        output hmc_rd_data_ready,
        input  hmc_errstat, hmc_dinv, bad_cmd, wr_err,
        input  axi_awvalid, axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
               axi_awlock, axi_awcache, axi_awprot, axi_awqos,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bid, axi_bresp, axi_bvalid,
        input  axi_bready,
        input  axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
               axi_arlock, axi_arcache, axi_arprot, axi_arqos,
        output axi_arready,
        output axi_rid, axi_rresp, axi_rdata, axi_rlast, axi_rvalid,
        input  axi_rready
    );
endinterface

// File: rtl/hmc_to_axi.sv
// Bridges HMC-style read/write commands onto an AXI4 master port.
// Writes pass W beats straight through; read beats are buffered in a 2-entry FIFO.
module hmc_to_axi #(
    parameter int         C_AXI_ID_WIDTH   = 6,
    parameter int         C_AXI_ADDR_WIDTH = 34,
    parameter logic [3:0] CMD_RD           = 4'h1,
    parameter logic [3:0] CMD_WR           = 4'h2
) (
    input logic         clk,
    input logic         rst,
    hmc_to_axi_if.master bus
);

    typedef enum logic [1:0] {IDLE, RD_ADDR, WR_ADDR, WR_DATA} state_t;

    state_t                      state;
    state_t                      state_next;
    logic [3:0]                  cmd_r;
    logic [3:0]                  size_r;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_r;
    logic [5:0]                  tag_r;
    logic [7:0]                  beat_cnt;
    logic [7:0]                  len;
    logic [C_AXI_ID_WIDTH-1:0]   id;
    logic                        cmd_hs;
    logic                        w_hs;
    logic                        bad_cmd_r;
    logic                        wr_err_r;

    logic [134:0]                fifo_mem [0:1];
    logic [134:0]                head;
    logic                        wr_ptr;
    logic                        rd_ptr;
    logic [1:0]                  count;
    logic                        push;
    logic                        pop;
    logic                        unused_bits;

    assign cmd_hs = bus.hmc_cmd_valid && bus.hmc_cmd_ready;
    assign w_hs   = bus.axi_wvalid && bus.axi_wready;
    // A size of 0 wraps to 15 and therefore means a full 16-beat burst.
    assign len    = {4'b0000, size_r - 4'd1};

    always_comb begin
        id      = '0;
        id[5:0] = tag_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_hs) begin
                    if (bus.hmc_cmd == CMD_RD)      state_next = RD_ADDR;
                    else if (bus.hmc_cmd == CMD_WR) state_next = WR_ADDR;
                end
            end
            RD_ADDR: if (bus.axi_arready) state_next = IDLE;
            WR_ADDR: if (bus.axi_awready) state_next = WR_DATA;
            WR_DATA: if (w_hs && beat_cnt == 8'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.hmc_cmd_ready     = (state == IDLE) && !rst;
        bus.axi_arvalid       = (state == RD_ADDR);
        bus.axi_awvalid       = (state == WR_ADDR);
        bus.axi_wvalid        = (state == WR_DATA) && bus.hmc_wr_data_valid;
        bus.hmc_wr_data_ready = (state == WR_DATA) && bus.axi_wready;
        bus.axi_wlast         = (state == WR_DATA) && (beat_cnt == 8'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_r     <= '0;
            size_r    <= '0;
            addr_r    <= '0;
            tag_r     <= '0;
            beat_cnt  <= '0;
            bad_cmd_r <= 1'b0;
            wr_err_r  <= 1'b0;
        end else begin
            if (cmd_hs) begin
                cmd_r  <= bus.hmc_cmd;
                size_r <= bus.hmc_size;
                addr_r <= bus.hmc_addr;
                tag_r  <= bus.hmc_tag;
                if (bus.hmc_cmd != CMD_RD && bus.hmc_cmd != CMD_WR) bad_cmd_r <= 1'b1;
            end
            if (state == WR_ADDR && bus.axi_awready)  beat_cnt <= len;
            else if (w_hs && beat_cnt != 8'd0)        beat_cnt <= beat_cnt - 8'd1;
            if (bus.axi_bvalid && bus.axi_bresp[1])   wr_err_r <= 1'b1;
        end
    end

    assign bus.axi_awid    = id;
    assign bus.axi_awaddr  = addr_r;
    assign bus.axi_awlen   = len;
    assign bus.axi_awsize  = 3'b100;
    assign bus.axi_awburst = 2'b01;
    assign bus.axi_awlock  = 1'b0;
    assign bus.axi_awcache = 4'b0011;
    assign bus.axi_awprot  = 3'b000;
    assign bus.axi_awqos   = 4'b0000;
    assign bus.axi_arid    = id;
    assign bus.axi_araddr  = addr_r;
    assign bus.axi_arlen   = len;
    assign bus.axi_arsize  = 3'b100;
    assign bus.axi_arburst = 2'b01;
    assign bus.axi_arlock  = 1'b0;
    assign bus.axi_arcache = 4'b0011;
    assign bus.axi_arprot  = 3'b000;
    assign bus.axi_arqos   = 4'b0000;
    assign bus.axi_wdata   = bus.hmc_wr_data;
    assign bus.axi_wstrb   = '1;
    assign bus.axi_bready  = 1'b1;
    assign bus.bad_cmd     = bad_cmd_r;
    assign bus.wr_err      = wr_err_r;

    // Read-return FIFO: each entry holds {tag, error bit, data}.
    assign push                  = bus.axi_rvalid && bus.axi_rready;
    assign pop                   = bus.hmc_rd_data_valid && bus.hmc_rd_data_ready;
    assign bus.axi_rready        = !rst && (count != 2'd2);
    assign bus.hmc_rd_data_valid = (count != 2'd0);
    assign head                  = fifo_mem[rd_ptr];
    assign bus.hmc_rd_data       = head[127:0];
    assign bus.hmc_errstat       = {6'b000000, head[128]};
    assign bus.hmc_rd_data_tag   = head[134:129];
    assign bus.hmc_dinv          = 1'b0;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {bus.axi_rid[5:0], bus.axi_rresp[1], bus.axi_rdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign unused_bits = ^{cmd_r, bus.axi_bid, bus.axi_bresp[0], bus.axi_rresp[0], bus.axi_rlast};

endmodule

// File: tb/tb_hmc_to_axi.sv
// Self-checking bench for hmc_to_axi: directed command table, random transactions,
// FIFO back-pressure, error flags and mid-burst reset, checked against a queue model.
module tb_hmc_to_axi;

    localparam logic [3:0] CMD_RD = 4'h1;
    localparam logic [3:0] CMD_WR = 4'h2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hmc_to_axi_if #(.C_AXI_ID_WIDTH(6), .C_AXI_ADDR_WIDTH(34)) bus ();

    hmc_to_axi #(
        .C_AXI_ID_WIDTH(6), .C_AXI_ADDR_WIDTH(34), .CMD_RD(CMD_RD), .CMD_WR(CMD_WR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [3:0]  size;
        logic [5:0]  tag;
        logic [33:0] addr;
        int          kind;
        logic [7:0]  exp_len;
        int          exp_beats;
    } vec_t;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.hmc_cmd_valid = 0; bus.hmc_cmd = 0; bus.hmc_addr = 0; bus.hmc_size = 0; bus.hmc_tag = 0;
        bus.hmc_wr_data = 0; bus.hmc_wr_data_valid = 0; bus.hmc_rd_data_ready = 0;
        bus.axi_awready = 0; bus.axi_wready = 0; bus.axi_bid = 0; bus.axi_bresp = 0; bus.axi_bvalid = 0;
        bus.axi_arready = 0; bus.axi_rid = 0; bus.axi_rresp = 0; bus.axi_rdata = 0;
        bus.axi_rlast = 0; bus.axi_rvalid = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] cmd, input logic [3:0] size, input logic [5:0] tag,
                                 input logic [33:0] addr);
        int n = 0;
        bus.hmc_cmd_valid = 1; bus.hmc_cmd = cmd; bus.hmc_size = size; bus.hmc_tag = tag; bus.hmc_addr = addr;
        while (!bus.hmc_cmd_ready && n < 50) begin
            step();
            n++;
        end
        if (n == 50) checkOutput("cmd_ready_timeout", 0, 1);
        step();
        bus.hmc_cmd_valid = 0;
    endtask

    task automatic do_read(input logic [3:0] size, input logic [5:0] tag, input logic [33:0] addr,
                           input logic [7:0] exp_len, input int exp_beats, input bit stall);
        logic [127:0] exp_data[$];
        logic         exp_err[$];
        int           offered = 0, received = 0, cyc = 0, dly;
        bit           accepted;
        applyStimulus(CMD_RD, size, tag, addr);
        checkOutput("arvalid", bus.axi_arvalid, 1);
        checkOutput("awvalid_on_read", bus.axi_awvalid, 0);
        checkOutput("arlen", bus.axi_arlen, exp_len);
        checkOutput("arid", bus.axi_arid, {122'd0, tag});
        checkOutput("arsize_burst_cache", {bus.axi_arsize, bus.axi_arburst, bus.axi_arcache}, {3'b100, 2'b01, 4'b0011});
        checkOutput("cmd_ready_busy_rd", bus.hmc_cmd_ready, 0);
        dly = $urandom_range(0, 2);
        for (int i = 0; i < dly; i++) begin
            step();
            checkOutput("araddr_hold", {bus.axi_arvalid, bus.axi_araddr}, {1'b1, addr});
        end
        checkOutput("araddr", bus.axi_araddr, addr);
        bus.axi_arready = 1;
        step();
        bus.axi_arready = 0;
        checkOutput("arvalid_drop", bus.axi_arvalid, 0);
        checkOutput("cmd_ready_after_ar", bus.hmc_cmd_ready, 1);
        while (received < exp_beats && cyc < 400) begin
            if (offered < exp_beats && !bus.axi_rvalid && (stall || $urandom_range(0, 3) != 0)) begin
                bus.axi_rvalid = 1;
                bus.axi_rdata  = {$urandom, $urandom, $urandom, $urandom};
                bus.axi_rresp  = 2'($urandom_range(0, 3));
                bus.axi_rid    = tag;
                bus.axi_rlast  = (offered == exp_beats - 1);
            end
            bus.hmc_rd_data_ready = (stall && cyc < 12) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            if (stall && cyc == 11) begin
                checkOutput("rready_full", bus.axi_rready, 0);
                checkOutput("rd_accepted_while_stalled", offered, 2);
            end
            if (bus.hmc_rd_data_valid && bus.hmc_rd_data_ready) begin
                if (exp_data.size() == 0) begin
                    checkOutput("rd_unexpected_beat", 1, 0);
                end else begin
                    checkOutput("rd_data", bus.hmc_rd_data, exp_data.pop_front());
                    checkOutput("rd_errstat", bus.hmc_errstat, {6'd0, exp_err.pop_front()});
                    checkOutput("rd_tag_dinv", {bus.hmc_rd_data_tag, bus.hmc_dinv}, {tag, 1'b0});
                end
                received++;
            end
            accepted = bus.axi_rvalid && bus.axi_rready;
            if (accepted) begin
                exp_data.push_back(bus.axi_rdata);
                exp_err.push_back(bus.axi_rresp[1]);
                offered++;
            end
            step();
            if (accepted) bus.axi_rvalid = 0;
            cyc++;
        end
        if (received < exp_beats) checkOutput("rd_timeout", received, exp_beats);
        bus.axi_rvalid = 0;
        bus.hmc_rd_data_ready = 0;
        step();
        checkOutput("rd_no_extra_beat", bus.hmc_rd_data_valid, 0);
    endtask

    task automatic do_write(input logic [3:0] size, input logic [5:0] tag, input logic [33:0] addr,
                            input logic [7:0] exp_len, input int exp_beats, input int abort_after);
        int           beats = 0, cyc = 0, dly;
        bit           hs;
        logic [127:0] wd = '0;
        applyStimulus(CMD_WR, size, tag, addr);
        checkOutput("awvalid", bus.axi_awvalid, 1);
        checkOutput("arvalid_on_write", bus.axi_arvalid, 0);
        checkOutput("awlen", bus.axi_awlen, exp_len);
        checkOutput("awid", bus.axi_awid, {122'd0, tag});
        checkOutput("aw_fixed", {bus.axi_awsize, bus.axi_awburst, bus.axi_awlock, bus.axi_awcache,
                                 bus.axi_awprot, bus.axi_awqos}, {3'b100, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000});
        dly = $urandom_range(0, 2);
        for (int i = 0; i < dly; i++) begin
            step();
            checkOutput("awaddr_hold", {bus.axi_awvalid, bus.axi_awaddr}, {1'b1, addr});
        end
        checkOutput("awaddr", bus.axi_awaddr, addr);
        bus.axi_awready = 1;
        step();
        bus.axi_awready = 0;
        checkOutput("awvalid_drop", bus.axi_awvalid, 0);
        while (beats < exp_beats && cyc < 400) begin
            if (!bus.hmc_wr_data_valid && $urandom_range(0, 3) != 0) begin
                bus.hmc_wr_data_valid = 1;
                wd = {$urandom, $urandom, $urandom, $urandom};
                bus.hmc_wr_data = wd;
            end
            bus.axi_wready = 1'($urandom_range(0, 1));
            #1;
            checkOutput("wvalid_pass", bus.axi_wvalid, bus.hmc_wr_data_valid);
            checkOutput("wready_pass", bus.hmc_wr_data_ready, bus.axi_wready);
            checkOutput("cmd_ready_busy_wr", bus.hmc_cmd_ready, 0);
            hs = bus.hmc_wr_data_valid && bus.axi_wready;
            if (hs) begin
                beats++;
                checkOutput("wdata", bus.axi_wdata, wd);
                checkOutput("wlast", bus.axi_wlast, beats == exp_beats);
                checkOutput("wstrb", bus.axi_wstrb, 16'hFFFF);
            end
            step();
            if (hs) bus.hmc_wr_data_valid = 0;
            cyc++;
            if (abort_after != 0 && beats == abort_after) break;
        end
        if (abort_after != 0) begin
            bus.hmc_wr_data_valid = 1;
            bus.axi_wready = 1;
            #1;
            checkOutput("wvalid_before_rst", bus.axi_wvalid, 1);
            rst = 1;
            #1;
            checkOutput("rst_valids", {bus.axi_wvalid, bus.axi_awvalid, bus.axi_arvalid, bus.hmc_rd_data_valid}, 0);
            checkOutput("rst_readies", {bus.hmc_cmd_ready, bus.axi_rready, bus.hmc_wr_data_ready}, 0);
            clearInputs();
            step();
            step();
            rst = 0;
            #1;
            checkOutput("cmd_ready_after_rst", bus.hmc_cmd_ready, 1);
            checkOutput("wvalid_after_rst", bus.axi_wvalid, 0);
            return;
        end
        if (beats < exp_beats) checkOutput("wr_timeout", beats, exp_beats);
        checkOutput("cmd_ready_after_wr", bus.hmc_cmd_ready, 1);
        bus.hmc_wr_data_valid = 1;
        bus.axi_wready = 1;
        #1;
        checkOutput("no_extra_w", {bus.axi_wvalid, bus.hmc_wr_data_ready}, 0);
        bus.hmc_wr_data_valid = 0;
        bus.axi_wready = 0;
    endtask

    task automatic run_vec(input vec_t v);
        case (v.kind)
            0: do_read(v.size, v.tag, v.addr, v.exp_len, v.exp_beats, 1'b0);
            1: do_write(v.size, v.tag, v.addr, v.exp_len, v.exp_beats, 0);
            default: begin
                applyStimulus(v.cmd, v.size, v.tag, v.addr);
                checkOutput("bad_cmd_set", bus.bad_cmd, 1);
                checkOutput("bad_cmd_idle", bus.hmc_cmd_ready, 1);
                for (int i = 0; i < 3; i++) begin
                    checkOutput("bad_cmd_no_axi", {bus.axi_arvalid, bus.axi_awvalid, bus.axi_wvalid}, 0);
                    step();
                end
            end
        endcase
    endtask

    initial begin
        vec_t vecs[6];
        vec_t rv;
        vecs[0] = '{CMD_RD, 4'd4, 6'd5,  34'h100,        0, 8'd3,  4};
        vecs[1] = '{CMD_WR, 4'd2, 6'd9,  34'h2000,       1, 8'd1,  2};
        vecs[2] = '{CMD_WR, 4'd0, 6'd17, 34'h3_0000_0000, 1, 8'd15, 16};
        vecs[3] = '{CMD_RD, 4'd1, 6'd63, 34'h3_FFFF_FFF0, 0, 8'd0,  1};
        vecs[4] = '{4'hF,   4'd3, 6'd1,  34'h0,          2, 8'd0,  0};
        vecs[5] = '{CMD_RD, 4'd0, 6'd2,  34'h40,         0, 8'd15, 16};

        clearInputs();
        #2 rst = 1;
        #1;
        checkOutput("reset_valids", {bus.axi_arvalid, bus.axi_awvalid, bus.axi_wvalid, bus.hmc_rd_data_valid}, 0);
        checkOutput("reset_readies", {bus.hmc_cmd_ready, bus.axi_rready}, 0);
        checkOutput("reset_flags", {bus.bad_cmd, bus.wr_err}, 0);
        step();
        step();
        rst = 0;
        #1;
        checkOutput("idle_cmd_ready", bus.hmc_cmd_ready, 1);
        checkOutput("bready_high", bus.axi_bready, 1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        for (int i = 0; i < 12; i++) begin
            rv.kind      = $urandom_range(0, 1);
            rv.cmd       = (rv.kind == 0) ? CMD_RD : CMD_WR;
            rv.size      = 4'($urandom_range(0, 15));
            rv.tag       = 6'($urandom_range(0, 63));
            rv.addr      = {2'($urandom_range(0, 3)), 32'($urandom)};
            rv.exp_beats = (rv.size == 0) ? 16 : int'(rv.size);
            rv.exp_len   = 8'(rv.exp_beats - 1);
            run_vec(rv);
        end

        do_read(4'd5, 6'd12, 34'h1_2345_6780, 8'd4, 5, 1'b1);

        do_write(4'd4, 6'd3, 34'h500, 8'd3, 4, 1);
        do_read(4'd2, 6'd33, 34'h600, 8'd1, 2, 1'b0);

        applyStimulus(4'hF, 4'd1, 6'd0, 34'h0);
        checkOutput("bad_cmd_again", bus.bad_cmd, 1);
        bus.axi_bvalid = 1; bus.axi_bresp = 2'b00;
        step();
        bus.axi_bresp = 2'b01;
        step();
        bus.axi_bvalid = 0;
        checkOutput("wr_err_okay_resp", bus.wr_err, 0);
        bus.axi_bvalid = 1; bus.axi_bresp = 2'b10;
        step();
        bus.axi_bvalid = 0;
        checkOutput("wr_err_slverr", bus.wr_err, 1);
        step();
        checkOutput("wr_err_sticky", bus.wr_err, 1);
        rst = 1;
        #1;
        checkOutput("rst_clears_flags", {bus.bad_cmd, bus.wr_err}, 0);
        step();
        rst = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
